// File: rtl/rv_adcavg.sv
// rv_adcavg -- per-channel ADC block averager with a small register bus.
//
// Eight channels each own an 18-bit accumulator and a 7-bit sample counter.
// When 2^N samples have been collected on a channel, their truncated mean is
// latched into AVG[ch], FRESH[ch] is set and the block restarts. A channel
// whose new average exceeds its threshold raises OVR[ch]. irq is the OR of
// OVR bits enabled by IMASK.
//
// Ports
//   clk        bus clock, all state on the rising edge
//   xreset     asynchronous active-low reset
//   adr        register word address (5 bits)
//   cs         peripheral select
//   rdy        bus ready, constant 1 (no wait states)
//   we         byte write enables, lane i covers dw[8i+7:8i]
//   re         read strobe
//   dw         write data
//   dr         registered read data, holds between reads
//   smp_valid  sample strobe from the ADC capture stage
//   smp_ch     sample channel 0..7
//   smp_data   unsigned 12-bit sample
//   smp_ready  sample accept, equals CTRL.EN
//   irq        level interrupt, |(OVR & IMASK)
//
// Register map
//   0-7    AVG[ch]  RO   bit31 FRESH (cleared by read), bits11:0 average
//   8      CTRL     RW   bits2:0 N (saturates at 6), bit8 EN, bits23:16 IMASK
//   9      STAT     W1C  bits7:0 OVR
//   16-23  THR[ch]  RW   bits11:0
//   other           reads 0, writes ignored

module rv_adcavg (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  output logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  input  logic        smp_valid,
  input  logic [2:0]  smp_ch,
  input  logic [11:0] smp_data,
  output logic        smp_ready,
  output logic        irq
);

  // Largest block is 2^6 samples; larger N requests are clamped.
  function automatic logic [2:0] sat_n(input logic [2:0] v);
    if (v > 3'd6) begin
      return 3'd6;
    end else begin
      return v;
    end
  endfunction

  // Registered state
  logic [2:0]  ctrl_n_q,     ctrl_n_d;
  logic        ctrl_en_q,    ctrl_en_d;
  logic [7:0]  ctrl_imask_q, ctrl_imask_d;
  logic [7:0]  ovr_q,        ovr_d;
  logic [7:0]  fresh_q,      fresh_d;
  logic [11:0] avg_q [8];
  logic [11:0] avg_d [8];
  logic [11:0] thr_q [8];
  logic [11:0] thr_d [8];
  logic [17:0] acc_q [8];
  logic [17:0] acc_d [8];
  logic [6:0]  cnt_q [8];
  logic [6:0]  cnt_d [8];
  logic [31:0] dr_q,         dr_d;

  // Decode and datapath signals
  logic        wr_s;
  logic        rd_s;
  logic        sel_avg_s;
  logic        sel_ctrl_s;
  logic        sel_stat_s;
  logic        sel_thr_s;
  logic [2:0]  n_wr_s;
  logic        n_change_s;
  logic        accept_s;
  logic [6:0]  blk_last_s;
  logic [18:0] sum_s;
  logic [18:0] shifted_s;
  logic [11:0] avg_new_s;
  logic        complete_s;
  logic [31:0] rdata_s;

  assign wr_s       = cs & (|we);
  assign rd_s       = cs & re;
  assign sel_avg_s  = (adr[4:3] == 2'b00);
  assign sel_ctrl_s = (adr == 5'd8);
  assign sel_stat_s = (adr == 5'd9);
  assign sel_thr_s  = (adr[4:3] == 2'b10);

  // A CTRL write that alters N restarts every block; a sample arriving in
  // that same cycle belongs to neither the old nor the new block size.
  assign n_wr_s     = sat_n(dw[2:0]);
  assign n_change_s = wr_s & sel_ctrl_s & we[0] & (n_wr_s != ctrl_n_q);
  assign accept_s   = smp_valid & ctrl_en_q & ~n_change_s;

  // Block completes on the sample that brings the count to 2^N.
  assign blk_last_s = (7'd1 << ctrl_n_q) - 7'd1;
  assign sum_s      = {1'b0, acc_q[smp_ch]} + {7'd0, smp_data};
  assign shifted_s  = sum_s >> ctrl_n_q;
  assign avg_new_s  = shifted_s[11:0];
  assign complete_s = accept_s & (cnt_q[smp_ch] == blk_last_s);

  assign rdy       = 1'b1;
  assign dr        = dr_q;
  assign smp_ready = ctrl_en_q;
  assign irq       = |(ovr_q & ctrl_imask_q);

  // Read data multiplexer (reserved fields and unmapped addresses read 0)
  always_comb begin
    rdata_s = 32'd0;
    if (sel_avg_s) begin
      rdata_s = {fresh_q[adr[2:0]], 19'd0, avg_q[adr[2:0]]};
    end else if (sel_ctrl_s) begin
      rdata_s = {8'd0, ctrl_imask_q, 7'd0, ctrl_en_q, 5'd0, ctrl_n_q};
    end else if (sel_stat_s) begin
      rdata_s = {24'd0, ovr_q};
    end else if (sel_thr_s) begin
      rdata_s = {20'd0, thr_q[adr[2:0]]};
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Next-state logic: bus writes/reads first, then sample updates so that
  // hardware set events win over read-clear and write-1-clear.
  always_comb begin
    ctrl_n_d     = ctrl_n_q;
    ctrl_en_d    = ctrl_en_q;
    ctrl_imask_d = ctrl_imask_q;
    ovr_d        = ovr_q;
    fresh_d      = fresh_q;
    avg_d        = avg_q;
    thr_d        = thr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dr_d         = dr_q;

    // Bus read: capture pre-update value; AVG reads consume FRESH.
    if (rd_s) begin
      dr_d = rdata_s;
      if (sel_avg_s) begin
        fresh_d[adr[2:0]] = 1'b0;
      end else begin
        fresh_d = fresh_q;
      end
    end else begin
      dr_d = dr_q;
    end

    // Bus write
    if (wr_s && sel_ctrl_s) begin
      if (we[0]) begin
        ctrl_n_d = n_wr_s;
      end else begin
        ctrl_n_d = ctrl_n_q;
      end
      if (we[1]) begin
        ctrl_en_d = dw[8];
      end else begin
        ctrl_en_d = ctrl_en_q;
      end
      if (we[2]) begin
        ctrl_imask_d = dw[23:16];
      end else begin
        ctrl_imask_d = ctrl_imask_q;
      end
    end else if (wr_s && sel_stat_s) begin
      if (we[0]) begin
        ovr_d = ovr_q & ~dw[7:0];
      end else begin
        ovr_d = ovr_q;
      end
    end else if (wr_s && sel_thr_s) begin
      if (we[0]) begin
        thr_d[adr[2:0]][7:0] = dw[7:0];
      end else begin
        thr_d[adr[2:0]][7:0] = thr_q[adr[2:0]][7:0];
      end
      if (we[1]) begin
        thr_d[adr[2:0]][11:8] = dw[11:8];
      end else begin
        thr_d[adr[2:0]][11:8] = thr_q[adr[2:0]][11:8];
      end
    end else begin
      ctrl_n_d = ctrl_n_q;
    end

    // Sample path
    if (n_change_s) begin
      for (int i = 0; i < 8; i++) begin
        acc_d[i] = 18'd0;
        cnt_d[i] = 7'd0;
      end
    end else if (complete_s) begin
      acc_d[smp_ch]   = 18'd0;
      cnt_d[smp_ch]   = 7'd0;
      avg_d[smp_ch]   = avg_new_s;
      fresh_d[smp_ch] = 1'b1;
      if (avg_new_s > thr_q[smp_ch]) begin
        ovr_d[smp_ch] = 1'b1;
      end else begin
        ovr_d[smp_ch] = ovr_d[smp_ch];
      end
    end else if (accept_s) begin
      acc_d[smp_ch] = sum_s[17:0];
      cnt_d[smp_ch] = cnt_q[smp_ch] + 7'd1;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      ctrl_n_q     <= 3'd0;
      ctrl_en_q    <= 1'b0;
      ctrl_imask_q <= 8'd0;
      ovr_q        <= 8'd0;
      fresh_q      <= 8'd0;
      dr_q         <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        avg_q[i] <= 12'd0;
        thr_q[i] <= 12'd0;
        acc_q[i] <= 18'd0;
        cnt_q[i] <= 7'd0;
      end
    end else begin
      ctrl_n_q     <= ctrl_n_d;
      ctrl_en_q    <= ctrl_en_d;
      ctrl_imask_q <= ctrl_imask_d;
      ovr_q        <= ovr_d;
      fresh_q      <= fresh_d;
      dr_q         <= dr_d;
      avg_q        <= avg_d;
      thr_q        <= thr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_adcavg.sv
// Self-checking bench for rv_adcavg. Expected read data is queued when a
// read is issued and popped/compared when dr updates after the read edge.

module tb_rv_adcavg;

  logic        clk;
  logic        xreset;
  logic [4:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic [31:0] dr;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic        smp_ready;
  logic        irq;

  int n_cmp;
  int n_err;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  rv_adcavg dut (
    .clk       (clk),
    .xreset    (xreset),
    .adr       (adr),
    .cs        (cs),
    .rdy       (rdy),
    .we        (we),
    .re        (re),
    .dw        (dw),
    .dr        (dr),
    .smp_valid (smp_valid),
    .smp_ch    (smp_ch),
    .smp_data  (smp_data),
    .smp_ready (smp_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w);
    adr = a; dw = d; we = w; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; we = 4'd0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    adr = a; re = 1'b1; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; re = 1'b0;
    chk_val(tag_q.pop_front(), dr, exp_q.pop_front());
  endtask

  task automatic send(input logic [2:0] ch, input logic [11:0] d);
    smp_ch = ch; smp_data = d; smp_valid = 1'b1;
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  initial begin
    int unsigned sum;
    logic [11:0] d;
    n_cmp = 0; n_err = 0;
    xreset = 1'b0; adr = 5'd0; cs = 1'b0; we = 4'd0; re = 1'b0; dw = 32'd0;
    smp_valid = 1'b0; smp_ch = 3'd0; smp_data = 12'd0;

    // Reset state
    #12;
    chk_val("rst_dr", dr, 32'd0);
    chk_val("rst_ready", {31'd0, smp_ready}, 32'd0);
    chk_val("rst_irq", {31'd0, irq}, 32'd0);
    chk_val("rst_rdy", {31'd0, rdy}, 32'd1);
    xreset = 1'b1;
    @(posedge clk); #1;
    bus_read(5'd8, 32'd0, "rst_ctrl");

    // N=0 pass-through and read-clear of FRESH
    bus_write(5'd8, 32'h0000_0100, 4'hF);
    chk_val("en_ready", {31'd0, smp_ready}, 32'd1);
    send(3'd3, 12'h5A5);
    bus_read(5'd3, 32'h8000_05A5, "avg3_fresh");
    bus_read(5'd3, 32'h0000_05A5, "avg3_clr");

    // N=2 block of four
    bus_write(5'd8, 32'h0000_0102, 4'hF);
    send(3'd0, 12'd1); send(3'd0, 12'd2); send(3'd0, 12'd3);
    bus_read(5'd0, 32'h0000_0000, "avg0_partial");
    send(3'd0, 12'd5);
    bus_read(5'd0, 32'h8000_0002, "avg0_done");

    // N saturation, reserved bits, unmapped address, byte enables
    bus_write(5'd8, 32'hFFFF_FF07, 4'b0011);
    bus_read(5'd8, 32'h0000_0106, "ctrl_sat");
    bus_write(5'd21, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'd21, 32'h0000_0FFF, "thr5_resv");
    bus_write(5'd10, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'd10, 32'h0000_0000, "unmapped");

    // Threshold: equal does not flag, greater does; W1C clears irq
    bus_write(5'd9, 32'h0000_00FF, 4'hF);
    bus_write(5'd8, 32'h0020_0100, 4'hF);
    bus_write(5'd21, 32'h0000_0800, 4'hF);
    send(3'd5, 12'h800);
    bus_read(5'd9, 32'h0000_0000, "ovr_equal");
    chk_val("irq_equal", {31'd0, irq}, 32'd0);
    send(3'd5, 12'h801);
    bus_read(5'd9, 32'h0000_0020, "ovr_set");
    chk_val("irq_set", {31'd0, irq}, 32'd1);
    bus_write(5'd9, 32'h0000_0020, 4'hF);
    chk_val("irq_clr", {31'd0, irq}, 32'd0);

    // OVR set collides with W1C: set wins
    adr = 5'd9; dw = 32'h0000_0020; we = 4'hF; cs = 1'b1;
    smp_ch = 3'd5; smp_data = 12'h900; smp_valid = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; we = 4'd0; smp_valid = 1'b0;
    bus_read(5'd9, 32'h0000_0020, "ovr_collide");
    chk_val("irq_collide", {31'd0, irq}, 32'd1);
    bus_write(5'd9, 32'h0000_00FF, 4'hF);

    // Sample in the cycle N changes (0->1) is discarded
    adr = 5'd8; dw = 32'h0020_0101; we = 4'hF; cs = 1'b1;
    smp_ch = 3'd2; smp_data = 12'h123; smp_valid = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; we = 4'd0; smp_valid = 1'b0;
    bus_read(5'd2, 32'h0000_0000, "nchg_discard");

    // Completion colliding with AVG read: old value shown, FRESH kept
    bus_write(5'd8, 32'h0020_0100, 4'hF);
    adr = 5'd2; re = 1'b1; cs = 1'b1;
    smp_ch = 3'd2; smp_data = 12'h456; smp_valid = 1'b1;
    exp_q.push_back(32'h0000_0000); tag_q.push_back("rd_collide_old");
    @(posedge clk); #1;
    cs = 1'b0; re = 1'b0; smp_valid = 1'b0;
    chk_val(tag_q.pop_front(), dr, exp_q.pop_front());
    bus_read(5'd2, 32'h8000_0456, "rd_collide_fresh");

    // N=3 partial block, then N=4: only the new 16 samples count
    bus_write(5'd8, 32'h0020_0103, 4'hF);
    for (int i = 0; i < 5; i++) send(3'd1, 12'($urandom_range(0, 4095)));
    bus_write(5'd8, 32'h0020_0104, 4'hF);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      d = 12'($urandom_range(0, 4095));
      sum += 32'(d);
      if (i == 15) bus_read(5'd1, 32'h0000_0000, "avg1_pre");
      send(3'd1, d);
    end
    bus_read(5'd1, 32'h8000_0000 | (sum >> 4), "avg1_n4");

    // Reset mid-block
    bus_write(5'd8, 32'h0000_0102, 4'hF);
    send(3'd6, 12'd100); send(3'd6, 12'd200);
    xreset = 1'b0;
    #2;
    chk_val("mid_rst_dr", dr, 32'd0);
    chk_val("mid_rst_ready", {31'd0, smp_ready}, 32'd0);
    chk_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    xreset = 1'b1;
    bus_read(5'd8, 32'h0000_0000, "mid_rst_ctrl");
    bus_read(5'd21, 32'h0000_0000, "mid_rst_thr5");
    bus_read(5'd2, 32'h0000_0000, "mid_rst_avg2");
    bus_read(5'd9, 32'h0000_0000, "mid_rst_stat");
    bus_write(5'd8, 32'h0000_0102, 4'hF);
    send(3'd6, 12'd10); send(3'd6, 12'd20); send(3'd6, 12'd30); send(3'd6, 12'd41);
    bus_read(5'd6, 32'h8000_0019, "avg6_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_adcavg.md
RV_ADCAVG -- requirements
Module: rv_adcavg

Interface
REQ-001 clk  in  1  CPU bus clock; all state on rising edge.
REQ-002 xreset  in  1  asynchronous active-low reset.
REQ-003 adr  in  5  register word address.
REQ-004 cs  in  1  peripheral select.
REQ-005 rdy  out  1  bus ready; tied 1, no wait states.
REQ-006 we  in  4  byte write enables, dw lane i = we[i].
REQ-007 re  in  1  read strobe.
REQ-008 dw  in  32  write data.
REQ-009 dr  out  32  registered read data.
REQ-010 smp_valid  in  1  sample strobe from the ADC capture stage.
REQ-011 smp_ch  in  3  sample channel index, 0..7.
REQ-012 smp_data  in  12  unsigned sample.
REQ-013 smp_ready  out  1  sample accept; equals CTRL.EN.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Register map: adr 0-7 AVG[ch] read-only, with bit31 FRESH and bits11:0 average; adr 8 CTRL R/W, with bits2:0 N, bit8 EN and bits23:16 IMASK; adr 9 STAT, with bits7:0 OVR (write-1-clear); adr 16-23 THR[ch] R/W, bits11:0; all other addresses read 0 and ignore writes.
REQ-016 Read: when cs&re are sampled at edge k, dr holds the selected register from edge k onward; dr holds its value when no read occurs.
REQ-017 Write: when cs and any we bit are sampled at edge k, the enabled bytes update at edge k; reserved bits read 0; an N value above 6 saturates to 6.
REQ-018 Per channel: an 18-bit accumulator ACC and a 7-bit counter CNT.
REQ-019 Sample acceptance: a sample is accepted when smp_valid&smp_ready; on acceptance, ACC[ch] += smp_data and CNT[ch] += 1.
REQ-020 Block completion: when CNT[ch] = 2^N-1 on acceptance, at that same edge AVG[ch] <= (ACC[ch]+smp_data)>>N (truncate, 12 bits), FRESH[ch] <= 1, ACC[ch] <= 0 and CNT[ch] <= 0.
REQ-021 N=0 passes every sample straight to AVG (latency 1 clk from acceptance).
REQ-022 Threshold flag: on block completion, if the new average is strictly greater than THR[ch], OVR[ch] <= 1; equal to THR[ch] does not set the flag.
REQ-023 Read-clear: a bus read of AVG[ch] clears FRESH[ch] at the read edge; dr returns the pre-clear value.
REQ-024 Read-clear collision: when a completion on ch coincides with a read of AVG[ch], dr shows the old value and FRESH stays 1.
REQ-025 Write-1-clear collision: when an OVR set and a write-1-clear hit the same bit in the same cycle, the set wins.
REQ-026 Any CTRL write that changes N clears all ACC and CNT at that edge, and a sample accepted in that cycle is discarded.
REQ-027 EN=0 deasserts smp_ready; ACC and CNT hold their values; the bus remains fully functional.
REQ-028 irq = |(OVR & IMASK), combinational from registers, with no glitch path from bus inputs.
REQ-029 ACC cannot overflow: its maximum is 64*4095 < 2^18.

Reset
REQ-030 On xreset low, all registers clear asynchronously: AVG, FRESH, OVR, ACC, CNT, CTRL, THR and dr = 0, so smp_ready = 0 and irq = 0; rdy = 1.
REQ-031 Reset mid-block discards the partial accumulation; the first block after release starts at CNT=0.

Verification
REQ-032 Set CTRL=0x100 (N=0, EN); send ch3 data 0x5A5 -> read adr3 returns 0x80000 5A5 (FRESH=1), and a second read returns 0x000005A5.
REQ-033 Set N=2 and send ch0 samples 1,2,3,5 -> AVG0=2 after the 4th sample only; after 3 samples FRESH0=0.
REQ-034 Set THR5=0x800 and IMASK bit5; send ch5 average 0x800 -> no OVR; send 0x801 -> OVR5=1 and irq=1; write STAT=0x20 -> irq=0.
REQ-035 Send an OVR5-setting sample in the same cycle as a STAT write-1-clear of bit5 -> OVR5 remains 1.
REQ-036 Set N=3, send 5 samples on ch1, then write N=3->4 -> the next 16 samples produce exactly their mean, and prior samples are excluded.
REQ-037 Pulse xreset low mid-block with N=2 after 2 samples -> all registers read 0, smp_ready=0; after re-enable, 4 new samples produce their exact mean.
